// File: rtl/pwm_compare_stage.sv
// PWM compare stage fed by a free-running N-bit up or down counter.
// Duty values arrive over valid/ready into a one-entry pending buffer and are applied only at period start.
module pwm_compare_stage #(
    parameter int N    = 8,
    parameter bit MODE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  count,
    input  logic          en,
    input  logic [N:0]    duty_in,
    input  logic          duty_valid,
    output logic          duty_ready,
    output logic          pwm,
    output logic          period_done,
    output logic [15:0]   periods
);

    localparam logic [N:0]   DUTY_MAX   = {1'b1, {N{1'b0}}};
    localparam logic [N-1:0] PHASE_LAST = {N{1'b1}};

    logic [N-1:0] phase;
    logic         is_start;
    logic         is_end;
    logic         take;
    logic         apply;
    logic [N:0]   duty_clamped;
    logic [N:0]   duty_eff;

    logic [N:0]   pend_q,      pend_d;
    logic         pend_full_q, pend_full_d;
    logic [N:0]   active_q,    active_d;
    logic         ready_q,     ready_d;
    logic         pwm_q,       pwm_d;
    logic         done_q,      done_d;
    logic [15:0]  periods_q,   periods_d;

    // A down-counter is folded so that phase always runs 0..2^N-1 within a period.
    generate
        if (MODE) begin : g_phase_up
            assign phase = count;
        end else begin : g_phase_down
            assign phase = ~count;
        end
    endgenerate

    assign is_start     = (phase == '0);
    assign is_end       = (phase == PHASE_LAST);
    assign take         = duty_valid && ready_q;
    assign apply        = is_start && pend_full_q;
    assign duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    // The pending value must govern the start cycle itself, not just the cycles after it.
    assign duty_eff     = apply ? pend_q : active_q;

    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        periods_d   = periods_q;

        // take implies an empty buffer, so it can never coincide with apply.
        if (take) begin
            pend_d      = duty_clamped;
            pend_full_d = 1'b1;
        end else if (apply) begin
            pend_full_d = 1'b0;
        end

        if (apply) begin
            active_d = pend_q;
        end

        if (is_end) begin
            periods_d = periods_q + 16'd1;
        end

        ready_d = ~pend_full_d;
        pwm_d   = en && ({1'b0, phase} < duty_eff);
        done_d  = en && is_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            active_q    <= '0;
            ready_q     <= 1'b0;
            pwm_q       <= 1'b0;
            done_q      <= 1'b0;
            periods_q   <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            active_q    <= active_d;
            ready_q     <= ready_d;
            pwm_q       <= pwm_d;
            done_q      <= done_d;
            periods_q   <= periods_d;
        end
    end

    assign duty_ready  = ready_q;
    assign pwm         = pwm_q;
    assign period_done = done_q;
    assign periods     = periods_q;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage: one up-counter instance and one down-counter instance.
// Outputs are sampled 1 ns after each rising edge; expected values are hand-derived per scenario.
module tb_pwm_compare_stage;

    logic        clk;
    logic        rst;
    logic        en;

    logic [7:0]  up_count;
    logic [8:0]  up_duty_in;
    logic        up_duty_valid;
    logic        up_duty_ready;
    logic        up_pwm;
    logic        up_period_done;
    logic [15:0] up_periods;

    logic [7:0]  dn_count;
    logic [8:0]  dn_duty_in;
    logic        dn_duty_valid;
    logic        dn_duty_ready;
    logic        dn_pwm;
    logic        dn_period_done;
    logic [15:0] dn_periods;

    int total = 0;
    int bad   = 0;
    int exp_up_periods = 0;
    int exp_dn_periods = 0;

    pwm_compare_stage #(.N(8), .MODE(1'b1)) u_up (
        .clk         (clk),
        .rst         (rst),
        .count       (up_count),
        .en          (en),
        .duty_in     (up_duty_in),
        .duty_valid  (up_duty_valid),
        .duty_ready  (up_duty_ready),
        .pwm         (up_pwm),
        .period_done (up_period_done),
        .periods     (up_periods)
    );

    pwm_compare_stage #(.N(8), .MODE(1'b0)) u_dn (
        .clk         (clk),
        .rst         (rst),
        .count       (dn_count),
        .en          (en),
        .duty_in     (dn_duty_in),
        .duty_valid  (dn_duty_valid),
        .duty_ready  (dn_duty_ready),
        .pwm         (dn_pwm),
        .period_done (dn_period_done),
        .periods     (dn_periods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000 ns");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        en            = 1'b1;
        up_duty_valid = 1'b0;
        dn_duty_valid = 1'b0;
        up_duty_in    = '0;
        dn_duty_in    = '0;
        for (int i = 0; i < 2; i++) begin
            up_count = 8'(i);
            dn_count = 8'(255 - i);
            tick();
        end
        total++; if (up_pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %b expected 0", up_pwm); end
        total++; if (up_period_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", up_period_done); end
        total++; if (up_periods !== 16'd0) begin bad++; $display("FAIL reset_periods: got %0d expected 0", up_periods); end
        total++; if (up_duty_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_up: got %b expected 0", up_duty_ready); end
        total++; if (dn_duty_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_dn: got %b expected 0", dn_duty_ready); end
        total++; if (dn_pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm_dn: got %b expected 0", dn_pwm); end
        rst      = 1'b0;
        up_count = 8'd5;
        dn_count = 8'd5;
        tick();
        total++; if (up_duty_ready !== 1'b1) begin bad++; $display("FAIL release_ready_up: got %b expected 1", up_duty_ready); end
        total++; if (dn_duty_ready !== 1'b1) begin bad++; $display("FAIL release_ready_dn: got %b expected 1", dn_duty_ready); end
        total++; if (dn_periods !== 16'd0) begin bad++; $display("FAIL release_periods_dn: got %0d expected 0", dn_periods); end
    endtask

    task automatic test_up_duty64();
        up_duty_in    = 9'd64;
        up_duty_valid = 1'b1;
        up_count      = 8'd100;
        tick();
        up_duty_valid = 1'b0;
        $display("xfer up duty=64 at count=100");
        total++; if (up_duty_ready !== 1'b0) begin bad++; $display("FAIL up64_ready_after_xfer: got %b expected 0", up_duty_ready); end
        total++; if (up_pwm !== 1'b0) begin bad++; $display("FAIL up64_pwm_c100: got %b expected 0", up_pwm); end
        for (int c = 101; c < 256; c++) begin
            up_count = 8'(c);
            tick();
            total++; if (up_pwm !== 1'b0) begin bad++; $display("FAIL up64_pre_pwm c=%0d: got %b expected 0", c, up_pwm); end
            total++; if (up_duty_ready !== 1'b0) begin bad++; $display("FAIL up64_pre_ready c=%0d: got %b expected 0", c, up_duty_ready); end
            total++; if (up_period_done !== (c == 255)) begin bad++; $display("FAIL up64_pre_done c=%0d: got %b expected %b", c, up_period_done, (c == 255)); end
            if (c == 255) begin
                exp_up_periods++;
                total++; if (up_periods !== 16'(exp_up_periods)) begin bad++; $display("FAIL up64_pre_periods: got %0d expected %0d", up_periods, exp_up_periods); end
            end
        end
        for (int c = 0; c < 256; c++) begin
            up_count = 8'(c);
            tick();
            total++; if (up_pwm !== (c < 64)) begin bad++; $display("FAIL up64_pwm c=%0d: got %b expected %b", c, up_pwm, (c < 64)); end
            total++; if (up_period_done !== (c == 255)) begin bad++; $display("FAIL up64_done c=%0d: got %b expected %b", c, up_period_done, (c == 255)); end
            if (c == 0) begin
                total++; if (up_duty_ready !== 1'b1) begin bad++; $display("FAIL up64_ready_after_start: got %b expected 1", up_duty_ready); end
            end
            if (c == 255) begin
                exp_up_periods++;
                total++; if (up_periods !== 16'(exp_up_periods)) begin bad++; $display("FAIL up64_periods: got %0d expected %0d", up_periods, exp_up_periods); end
            end
        end
        up_count = 8'd5;
    endtask

    task automatic test_extremes();
        int duties [3] = '{0, 256, 300};
        int cur = 64;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 256; c++) begin
                if (c == 0 && k > 0) cur = (duties[k-1] > 256) ? 256 : duties[k-1];
                up_count      = 8'(c);
                up_duty_valid = (c == 10 && k < 3);
                if (k < 3) up_duty_in = 9'(duties[k]);
                tick();
                if (c == 10 && k < 3) begin
                    $display("xfer up duty=%0d at count=10", duties[k]);
                    total++; if (up_duty_ready !== 1'b0) begin bad++; $display("FAIL ext_ready_full k=%0d: got %b expected 0", k, up_duty_ready); end
                end
                if (c == 1) begin
                    total++; if (up_duty_ready !== 1'b1) begin bad++; $display("FAIL ext_ready_empty k=%0d: got %b expected 1", k, up_duty_ready); end
                end
                total++; if (up_pwm !== (c < cur)) begin bad++; $display("FAIL ext_pwm k=%0d c=%0d: got %b expected %b", k, c, up_pwm, (c < cur)); end
                total++; if (up_period_done !== (c == 255)) begin bad++; $display("FAIL ext_done k=%0d c=%0d: got %b expected %b", k, c, up_period_done, (c == 255)); end
                if (c == 255) begin
                    exp_up_periods++;
                    total++; if (up_periods !== 16'(exp_up_periods)) begin bad++; $display("FAIL ext_periods k=%0d: got %0d expected %0d", k, up_periods, exp_up_periods); end
                end
            end
        end
        up_duty_valid = 1'b0;
        up_count      = 8'd5;
    endtask

    task automatic test_mode0();
        dn_duty_in    = 9'd16;
        dn_duty_valid = 1'b1;
        dn_count      = 8'd100;
        tick();
        dn_duty_valid = 1'b0;
        $display("xfer dn duty=16 at count=100");
        total++; if (dn_duty_ready !== 1'b0) begin bad++; $display("FAIL dn_ready_after_xfer: got %b expected 0", dn_duty_ready); end
        for (int c = 99; c >= 0; c--) begin
            dn_count = 8'(c);
            tick();
            total++; if (dn_pwm !== 1'b0) begin bad++; $display("FAIL dn_pre_pwm c=%0d: got %b expected 0", c, dn_pwm); end
            total++; if (dn_period_done !== (c == 0)) begin bad++; $display("FAIL dn_pre_done c=%0d: got %b expected %b", c, dn_period_done, (c == 0)); end
            if (c == 0) begin
                exp_dn_periods++;
                total++; if (dn_periods !== 16'(exp_dn_periods)) begin bad++; $display("FAIL dn_pre_periods: got %0d expected %0d", dn_periods, exp_dn_periods); end
            end
        end
        for (int c = 255; c >= 0; c--) begin
            dn_count = 8'(c);
            tick();
            total++; if (dn_pwm !== (c >= 240)) begin bad++; $display("FAIL dn_pwm c=%0d: got %b expected %b", c, dn_pwm, (c >= 240)); end
            total++; if (dn_period_done !== (c == 0)) begin bad++; $display("FAIL dn_done c=%0d: got %b expected %b", c, dn_period_done, (c == 0)); end
            if (c == 255) begin
                total++; if (dn_duty_ready !== 1'b1) begin bad++; $display("FAIL dn_ready_after_start: got %b expected 1", dn_duty_ready); end
            end
            if (c == 0) begin
                exp_dn_periods++;
                total++; if (dn_periods !== 16'(exp_dn_periods)) begin bad++; $display("FAIL dn_periods: got %0d expected %0d", dn_periods, exp_dn_periods); end
            end
        end
        dn_count = 8'd5;
    endtask

    task automatic test_back_to_back();
        int cur;
        bit exp_ready;
        for (int k = 0; k < 3; k++) begin
            cur = (k == 0) ? 256 : ((k == 1) ? 32 : 200);
            for (int c = 0; c < 256; c++) begin
                up_count = 8'(c);
                if (k == 0) begin
                    up_duty_valid = (c >= 10);
                    up_duty_in    = (c == 10) ? 9'd32 : 9'd200;
                    exp_ready     = (c < 10);
                end else if (k == 1) begin
                    up_duty_valid = (c <= 1);
                    up_duty_in    = 9'd200;
                    exp_ready     = (c == 0);
                end else begin
                    up_duty_valid = 1'b0;
                    exp_ready     = 1'b1;
                end
                tick();
                if (k == 0 && c == 10) $display("xfer up duty=32 at count=10");
                if (k == 1 && c == 1)  $display("xfer up duty=200 at count=1");
                total++; if (up_duty_ready !== exp_ready) begin bad++; $display("FAIL b2b_ready k=%0d c=%0d: got %b expected %b", k, c, up_duty_ready, exp_ready); end
                total++; if (up_pwm !== (c < cur)) begin bad++; $display("FAIL b2b_pwm k=%0d c=%0d: got %b expected %b", k, c, up_pwm, (c < cur)); end
                if (c == 255) begin
                    exp_up_periods++;
                    total++; if (up_periods !== 16'(exp_up_periods)) begin bad++; $display("FAIL b2b_periods k=%0d: got %0d expected %0d", k, up_periods, exp_up_periods); end
                end
            end
        end
        up_duty_valid = 1'b0;
        up_count      = 8'd5;
    endtask

    task automatic test_reset_mid();
        int cur;
        int c0;
        up_duty_in = 9'd128;
        for (int c = 0; c <= 50; c++) begin
            up_count      = 8'(c);
            up_duty_valid = (c == 10);
            if (c == 50) rst = 1'b1;
            tick();
            if (c == 10) $display("xfer up duty=128 at count=10");
            if (c == 50) begin
                rst = 1'b0;
                exp_up_periods = 0;
                total++; if (up_pwm !== 1'b0) begin bad++; $display("FAIL rmid_pwm_at_rst: got %b expected 0", up_pwm); end
                total++; if (up_periods !== 16'd0) begin bad++; $display("FAIL rmid_periods_at_rst: got %0d expected 0", up_periods); end
                total++; if (up_duty_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_at_rst: got %b expected 0", up_duty_ready); end
            end else begin
                total++; if (up_pwm !== (c < 200)) begin bad++; $display("FAIL rmid_pre_pwm c=%0d: got %b expected %b", c, up_pwm, (c < 200)); end
                total++; if (up_duty_ready !== (c < 10)) begin bad++; $display("FAIL rmid_pre_ready c=%0d: got %b expected %b", c, up_duty_ready, (c < 10)); end
            end
        end
        up_duty_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cur = (k == 2) ? 100 : 0;
            c0  = (k == 0) ? 51 : 0;
            for (int c = c0; c < 256; c++) begin
                up_count      = 8'(c);
                up_duty_valid = (k == 1 && c == 10);
                up_duty_in    = 9'd100;
                tick();
                if (k == 1 && c == 10) $display("xfer up duty=100 at count=10");
                if (k == 0 && c == 51) begin
                    total++; if (up_duty_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_release: got %b expected 1", up_duty_ready); end
                end
                total++; if (up_pwm !== (c < cur)) begin bad++; $display("FAIL rmid_pwm k=%0d c=%0d: got %b expected %b", k, c, up_pwm, (c < cur)); end
                if (c == 255) begin
                    exp_up_periods++;
                    total++; if (up_periods !== 16'(exp_up_periods)) begin bad++; $display("FAIL rmid_periods k=%0d: got %0d expected %0d", k, up_periods, exp_up_periods); end
                end
            end
        end
        up_duty_valid = 1'b0;
        up_count      = 8'd5;
    endtask

    task automatic test_enable();
        en = 1'b0;
        for (int c = 0; c < 256; c++) begin
            up_count = 8'(c);
            tick();
            total++; if (up_pwm !== 1'b0) begin bad++; $display("FAIL en_off_pwm c=%0d: got %b expected 0", c, up_pwm); end
            total++; if (up_period_done !== 1'b0) begin bad++; $display("FAIL en_off_done c=%0d: got %b expected 0", c, up_period_done); end
            if (c == 255) begin
                exp_up_periods++;
                total++; if (up_periods !== 16'(exp_up_periods)) begin bad++; $display("FAIL en_off_periods: got %0d expected %0d", up_periods, exp_up_periods); end
            end
        end
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            up_count = 8'(c);
            tick();
            total++; if (up_pwm !== 1'b1) begin bad++; $display("FAIL en_on_pwm c=%0d: got %b expected 1", c, up_pwm); end
        end
        up_count = 8'd5;
    endtask

    initial begin
        test_reset();
        test_up_duty64();
        test_extremes();
        test_mode0();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_compare_stage.md
Name: pwm_compare_stage

Overview:
- Downstream consumer of the free-running N-bit up/down counter.
- Compares the counter value against a double-buffered duty value and produces a registered PWM waveform, a one-cycle end-of-period pulse and a completed-period count.
- New duty values arrive over a valid/ready handshake and take effect only at a period boundary, so no glitched or partial periods occur.

Parameters:
- N, 8, counter width; period = 2^N clocks.
- MODE, 1, counter direction it consumes: 1 = up-counter (period starts at count 0), 0 = down-counter (period starts at count all-ones).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- count  input  N  counter value, sampled every clock.
- en  input  1  output enable; 0 forces pwm and period_done low.
- duty_in  input  N+1  requested high-time in clocks, 0..2^N.
- duty_valid  input  1  duty_in valid.
- duty_ready  output  1  pending buffer can accept a duty value.
- pwm  output  1  registered PWM output.
- period_done  output  1  one-cycle pulse after the last phase of a period.
- periods  output  16  completed-period count, wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at a clock edge): pwm=0, period_done=0, periods=0, active duty=0, pending buffer empty, duty_ready=0 while rst is held. duty_ready=1 on the first cycle after rst deasserts. A pending value present at reset is discarded.
- Phase: phase = count when MODE=1, ~count when MODE=0, so phase runs 0..2^N-1 in both modes.
- Period start: phase==0. Period end: phase==2^N-1.
- Handshake:
  - A transfer occurs when duty_valid && duty_ready at a clock edge.
  - duty_in is clamped to 2^N and stored in the one-entry pending buffer.
  - duty_ready = pending buffer empty, registered.
  - While the buffer is full, duty_ready=0. The source must hold duty_in and duty_valid until a transfer occurs.
- Update:
  - In a period-start cycle with the buffer full (as registered before that edge), the effective duty for that cycle = pending value.
  - At that edge the active duty takes the pending value and the buffer empties; duty_ready=1 the next cycle.
  - A transfer in the same cycle as a period start goes into the buffer and applies at the following period start.
- Compare: at each edge, pwm <= en && (phase < duty_eff), where duty_eff is the pending value on a period start with the buffer full, otherwise the active duty. Comparison is (N+1)-bit unsigned.
  - Latency: pwm reflects the count sampled one cycle earlier.
  - duty=0 gives constant 0; duty=2^N gives constant 1.
- period_done <= en && (phase==2^N-1), a one-cycle pulse aligned with the pwm bit for the last phase.
- periods increments by 1 on every phase==2^N-1 sample, regardless of en. 0xFFFF wraps to 0.
- The block does not check that count is sequential; only phase equality is used for boundaries. If count jumps over the start value, no update occurs that period.
- en=0 gates pwm and period_done only. Handshake, updates and periods keep running.

Test Plan:
- Reset: hold rst=1 for 2 cycles with count toggling -> pwm=0, period_done=0, periods=0, duty_ready=0; one cycle after release, duty_ready=1.
- N=8, MODE=1, up-count: transfer duty 64 at count=100 -> duty_ready=0 and pwm stays 0 through count 255. From the count=0 sample, pwm=1 for samples 0..63 (one cycle late) and 0 for 64..255. duty_ready=1 the cycle after the count=0 sample.
- Extremes: duty 0 -> pwm constantly 0. duty 256 -> pwm constantly 1. duty 300 -> clamped to 256, pwm constantly 1. period_done pulses once per 256 cycles and periods increments at each pulse.
- MODE=0, count descending 255..0, duty 16 -> pwm=1 for count samples 255..240 and 0 for 239..0. period_done follows the count=0 sample.
- Back-to-back: transfer 32 at count=10, then hold duty_valid with 200 -> 200 is not accepted until after the count=0 edge. The next period uses 32; the period after uses 200.
- Reset mid-operation: pending 128 buffered, rst pulsed at count=50 -> the pending value is lost, active duty=0, and pwm stays 0 in following periods until a new transfer is made.
